// File: rtl/stack_pkg.sv
// Shared constants, operation encoding and width helper for the stack unit.
package stack_pkg;

  localparam int STACK_DATA_W = 4;
  localparam int STACK_DEPTH  = 256;

  // Decoded operation for one clock edge.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } op_t;

  // Ceiling log2, usable in constant (parameter) context.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stack_if.sv
// Store-bus side of the stack: push/pop controls in, top/peek/status out.
interface stack_if
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int ADDR_W = clog2(STACK_DEPTH)
);

  logic              push;
  logic              pop;
  logic              err_clr;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              udf;

  // CPU core side.
  modport master (
    output push, pop, err_clr, din, rd_idx,
    input  dout, rd_data, sp, count, empty, full, ovf, udf
  );

  // Stack unit side.
  modport slave (
    input  push, pop, err_clr, din, rd_idx,
    output dout, rd_data, sp, count, empty, full, ovf, udf
  );

endinterface

// File: rtl/stack_ram.sv
// Register-array storage: one synchronous write port, two combinational reads.
// Contents are deliberately not reset.
module stack_ram
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int ADDR_W = clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_unit.sv
// Parametrised LIFO: pointer, count and sticky error flags around stack_ram.
// SP is the next free slot; the top entry sits one step back from it.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W    = STACK_DATA_W,
  parameter int DEPTH     = STACK_DEPTH,
  parameter int GROW_DOWN = 1
) (
  input logic   clk,
  input logic   rst,
  stack_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SP_RESET  = (GROW_DOWN != 0) ? ADDR_W'(DEPTH - 1) : '0;
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic              udf_q;

  logic [ADDR_W-1:0] sp_grow;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] peek;
  logic              is_empty;
  logic              is_full;
  op_t               op;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_udf;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] top_data;
  logic [DATA_W-1:0] peek_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == COUNT_MAX);

  // Pointer neighbours: growth direction for push, top is one step back.
  always_comb begin
    if (GROW_DOWN != 0) begin
      sp_grow = sp_q - ONE_A;
      top     = sp_q + ONE_A;
      peek    = top + bus.rd_idx;
    end else begin
      sp_grow = sp_q + ONE_A;
      top     = sp_q - ONE_A;
      peek    = top - bus.rd_idx;
    end
  end

  // Decode push/pop; push+pop on an empty stack degrades to a plain push.
  always_comb begin
    op = OP_NONE;
    case ({bus.push, bus.pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = is_empty ? OP_PUSH : OP_REPL;
      default: op = OP_NONE;
    endcase
  end

  assign do_push = (op == OP_PUSH) && !is_full;
  assign do_pop  = (op == OP_POP)  && !is_empty;
  assign set_ovf = (op == OP_PUSH) && is_full;
  assign set_udf = (op == OP_POP)  && is_empty;

  // Replace overwrites the current top; a push fills the free slot.
  assign we    = do_push || (op == OP_REPL);
  assign waddr = (op == OP_REPL) ? top : sp_q;

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (we && !rst),
    .waddr   (waddr),
    .wdata   (bus.din),
    .raddr_a (top),
    .rdata_a (top_data),
    .raddr_b (peek),
    .rdata_b (peek_data)
  );

  // Pointer, count and sticky flags; a new error outranks err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= SP_RESET;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        sp_q    <= sp_grow;
        count_q <= count_q + ONE_C;
      end else if (do_pop) begin
        sp_q    <= top;
        count_q <= count_q - ONE_C;
      end
      ovf_q <= set_ovf || (ovf_q && !bus.err_clr);
      udf_q <= set_udf || (udf_q && !bus.err_clr);
    end
  end

  assign bus.dout    = is_empty ? '0 : top_data;
  assign bus.rd_data = ({1'b0, bus.rd_idx} < count_q) ? peek_data : '0;
  assign bus.sp      = sp_q;
  assign bus.count   = count_q;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit (DATA_W=4, DEPTH=4, GROW_DOWN=1).
// The driver pushes expected outputs from a queue-based LIFO model;
// the monitor pops and compares on the falling edge.
module tb_stack_unit;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  typedef struct {
    logic [3:0] dout;
    logic [3:0] rd_data;
    logic [1:0] sp;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       udf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  stack_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GROW_DOWN(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [3:0] stk[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic       drv_done = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current model state and a given peek depth.
  function automatic exp_t model_outputs(input int idx);
    exp_t e;
    int n;
    n = stk.size();
    e.dout    = (n > 0) ? stk[n-1] : 4'h0;
    e.rd_data = (idx < n) ? stk[n-1-idx] : 4'h0;
    e.sp      = 2'(((DEPTH - 1 - n) % DEPTH + DEPTH) % DEPTH);
    e.count   = 3'(n);
    e.empty   = (n == 0);
    e.full    = (n == DEPTH);
    e.ovf     = m_ovf;
    e.udf     = m_udf;
    return e;
  endfunction

  task automatic model_update(input logic p, input logic po, input logic c,
                              input logic [3:0] d, input logic r);
    logic n_ovf;
    logic n_udf;
    n_ovf = 1'b0;
    n_udf = 1'b0;
    if (r) begin
      stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (p && po && stk.size() > 0) begin
        stk[stk.size()-1] = d;
      end else if (p) begin
        if (stk.size() < DEPTH) stk.push_back(d);
        else n_ovf = 1'b1;
      end else if (po) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else n_udf = 1'b1;
      end
      m_ovf = n_ovf | (m_ovf & ~c);
      m_udf = n_udf | (m_udf & ~c);
    end
  endtask

  task automatic step(input logic p, input logic po, input logic c,
                      input logic [3:0] d, input logic [1:0] idx, input logic r);
    @(posedge clk);
    #1;
    sif.push    = p;
    sif.pop     = po;
    sif.err_clr = c;
    sif.din     = d;
    sif.rd_idx  = idx;
    rst         = r;
    exp_q.push_back(model_outputs(int'(idx)));
    model_update(p, po, c, d, r);
  endtask

  // Monitor: compare every presented expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dout",    8'(sif.dout),    8'(e.dout));
      chk("rd_data", 8'(sif.rd_data), 8'(e.rd_data));
      chk("sp",      8'(sif.sp),      8'(e.sp));
      chk("count",   8'(sif.count),   8'(e.count));
      chk("empty",   8'(sif.empty),   8'(e.empty));
      chk("full",    8'(sif.full),    8'(e.full));
      chk("ovf",     8'(sif.ovf),     8'(e.ovf));
      chk("udf",     8'(sif.udf),     8'(e.udf));
    end
  end

  // Driver: directed scenarios, then randomized phases.
  initial begin
    rst = 1'b1;
    sif.push = 1'b0; sif.pop = 1'b0; sif.err_clr = 1'b0;
    sif.din = '0; sif.rd_idx = '0;

    step(0, 0, 0, 4'h0, 2'd0, 1);
    step(0, 0, 0, 4'h0, 2'd0, 0);
    step(0, 0, 0, 4'h0, 2'd0, 0);
    step(1, 0, 0, 4'hA, 2'd0, 0);
    step(1, 0, 0, 4'hB, 2'd0, 0);
    step(1, 0, 0, 4'hC, 2'd0, 0);
    step(1, 0, 0, 4'hD, 2'd0, 0);
    step(0, 0, 0, 4'h0, 2'd3, 0);
    step(1, 0, 0, 4'hE, 2'd0, 0);
    step(0, 0, 1, 4'h0, 2'd0, 0);
    step(1, 0, 1, 4'hE, 2'd0, 0);
    step(1, 1, 0, 4'h5, 2'd1, 0);
    step(0, 1, 0, 4'h0, 2'd1, 0);
    step(0, 1, 0, 4'h0, 2'd0, 0);
    step(0, 1, 0, 4'h0, 2'd0, 0);
    step(0, 1, 0, 4'h0, 2'd0, 0);
    step(0, 0, 1, 4'h0, 2'd0, 0);
    step(0, 1, 0, 4'h0, 2'd0, 0);
    step(1, 1, 0, 4'h7, 2'd0, 0);
    step(1, 0, 0, 4'h1, 2'd1, 0);
    step(1, 0, 0, 4'h9, 2'd1, 1);
    step(0, 0, 0, 4'h0, 2'd0, 0);

    for (int i = 0; i < 600; i++) begin
      int pp;
      int pq;
      pp = (i < 200) ? 70 : (i < 400) ? 25 : 50;
      pq = (i < 200) ? 25 : (i < 400) ? 70 : 50;
      step(($urandom_range(99) < pp),
           ($urandom_range(99) < pq),
           ($urandom_range(7) == 0),
           4'($urandom_range(15)),
           2'($urandom_range(3)),
           ($urandom_range(59) == 0));
    end
    step(0, 0, 0, 4'h0, 2'd0, 0);
    drv_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    int waited;
    waited = 0;
    while (!drv_done && waited < 5000) begin
      @(posedge clk);
      waited = waited + 1;
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited = waited + 1;
    end
    checks = checks + 1;
    if (!drv_done || exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: pending %0d expected 0 (driver done %0b)", exp_q.size(), drv_done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
